// File: rtl/mem_lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
// Access size is taken from funct3[1:0]: bit 1 set = word, else bit 0 set = half, else byte.
package mem_lsu_pkg;

    typedef enum logic {
        IDLE,
        BUSY
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

    function automatic logic [31:0] replicate_store(input logic [2:0] funct3,
                                                    input logic [31:0] data);
        logic [31:0] res;
        if (funct3[1]) begin
            res = data;
        end else if (funct3[0]) begin
            res = {2{data[15:0]}};
        end else begin
            res = {4{data[7:0]}};
        end
        return res;
    endfunction

    function automatic logic [3:0] size_strb(input logic [2:0] funct3);
        logic [3:0] res;
        if (funct3[1]) begin
            res = STRB_W;
        end else if (funct3[0]) begin
            res = STRB_H;
        end else begin
            res = STRB_B;
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/response bus between the LSU (master) and the memory (slave).
interface mem_stage_lsu_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, wstrb,
        input  ready, rdata
    );

    modport slave (
        input  req, we, addr, wdata, wstrb,
        output ready, rdata
    );
endinterface

// File: rtl/lsu_load_align.sv
// Combinational load formatter: lane extract from the read word plus sign/zero extension.
module lsu_load_align
    import mem_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[{addr_lo, 3'b000} +: 8];
        half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    load_data = {{24{byte_v[7]}}, byte_v};
            F3_BU:   load_data = {24'h0, byte_v};
            F3_H:    load_data = {{16{half_v[15]}}, half_v};
            F3_HU:   load_data = {16'h0, half_v};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one dmem access per instruction, stalls the pipe until done/timeout.
// Optional macro LSU_MISALIGN_TRAP_EN rejects misaligned accesses instead of truncating the address.
module mem_stage_lsu
    import mem_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid_in,
    input  logic                   mem_read_in,
    input  logic                   mem_write_in,
    input  logic [2:0]             funct3_in,
    input  logic [31:0]            addr_in,
    input  logic [31:0]            store_data_in,
    mem_stage_lsu_if.master        dmem,
    output logic [31:0]            load_data_out,
    output logic                   stall_out,
    output logic                   bus_err_out,
    output logic                   misalign_out
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntTerm = CntW'(TIMEOUT_CYCLES - 1);

    lsu_state_e state_q, state_d;

    logic [CntW-1:0] cnt_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [3:0]      strb_q;
    logic [2:0]      funct3_q;
    logic            we_q;

    logic        is_mem;
    logic        misaligned;
    logic        access;
    logic        cnt_term;
    logic [1:0]  addr_lo;
    logic [3:0]  strb_next;
    logic [31:0] aligned_load;

    assign is_mem   = valid_in & (mem_read_in | mem_write_in);
    assign access   = is_mem & ~misaligned;
    assign cnt_term = (cnt_q == CntTerm);

    always_comb begin
        addr_lo = addr_in[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
        misaligned = (funct3_in[1] && (addr_in[1:0] != 2'b00)) ||
                     (!funct3_in[1] && funct3_in[0] && addr_in[0]);
`else
        misaligned = 1'b0;
        // Without the trap, misaligned low bits are silently dropped.
        if (funct3_in[1]) begin
            addr_lo = 2'b00;
        end else if (funct3_in[0]) begin
            addr_lo[0] = 1'b0;
        end
`endif
        strb_next = size_strb(funct3_in) << addr_lo;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (access) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (dmem.ready || cnt_term) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            strb_q   <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
        end else if (state_q == IDLE && access) begin
            cnt_q    <= '0;
            addr_q   <= {addr_in[31:2], addr_lo};
            wdata_q  <= replicate_store(funct3_in, store_data_in);
            strb_q   <= mem_write_in ? strb_next : 4'b0000;
            funct3_q <= funct3_in;
            we_q     <= mem_write_in;
        end else if (state_q == BUSY && !dmem.ready && !cnt_term) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    lsu_load_align u_load_align (
        .rdata     (dmem.rdata),
        .addr_lo   (addr_q[1:0]),
        .funct3    (funct3_q),
        .load_data (aligned_load)
    );

    // Reset forces every output low, so an abandoned access cannot pulse bus_err_out.
    always_comb begin
        dmem.req      = 1'b0;
        dmem.we       = 1'b0;
        dmem.addr     = '0;
        dmem.wdata    = '0;
        dmem.wstrb    = '0;
        load_data_out = '0;
        stall_out     = 1'b0;
        bus_err_out   = 1'b0;
        misalign_out  = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    stall_out    = access;
                    misalign_out = is_mem & misaligned;
                end
                BUSY: begin
                    dmem.req   = 1'b1;
                    dmem.we    = we_q;
                    dmem.addr  = {addr_q[31:2], 2'b00};
                    dmem.wdata = wdata_q;
                    dmem.wstrb = strb_q;
                    if (dmem.ready) begin
                        if (!we_q) begin
                            load_data_out = aligned_load;
                        end
                    end else if (cnt_term) begin
                        bus_err_out = 1'b1;
                    end else begin
                        stall_out = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
